// File: rtl/mig7_pkg.sv
// mig7_pkg
//   Shared definitions for the MIG7 app-interface responder: command codes
//   understood on app_cmd and the controller state encoding.
package mig7_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_CALIB    = 2'd0,
    ST_READY    = 2'd1,
    ST_SR_ENTER = 2'd2,
    ST_SR       = 2'd3
  } mig7_resp_state_t;

endpackage

// File: rtl/mig7_resp_wdf_fifo.sv
// mig7_resp_wdf_fifo
//   4-deep synchronous FIFO holding write-data beats ({mask, data}) until the
//   matching WRITE command is available to commit them.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset (clears pointers only)
//     push, push_data   enqueue one beat (ignored when full)
//     pop          dequeue the head beat (ignored when empty)
//     head         current head beat (valid when !empty)
//     full, empty  occupancy flags
module mig7_resp_wdf_fifo #(
  parameter int WIDTH = 144
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [4];
  logic [1:0]       wr_ptr_reg;
  logic [1:0]       rd_ptr_reg;
  logic [2:0]       count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == 3'd4);
  assign empty   = (count_reg == 3'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_reg + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

endmodule

// File: rtl/mig7_app_responder.sv
// mig7_app_responder
//   Controller-side model of the MIG7 user (app_*) interface. Commands and
//   write data are accepted through the usual rdy handshakes, stored in an
//   internal RAM, and reads return after a fixed latency. Calibration,
//   refresh/ZQ acknowledgement and self-refresh entry/exit are modelled.
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     app_addr/app_cmd/app_en   command channel, app_rdy = accepted
//     app_wdf_*                 write-data channel, app_wdf_rdy = accepted
//     app_rd_data*              read-return channel
//     app_sr_req/app_sr_active  self-refresh request level / status
//     app_ref_*/app_zq_*        maintenance request pulse / ack pulse
//     init_calib_complete       high once calibration has finished
module mig7_app_responder
  import mig7_pkg::*;
#(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 128,
  parameter int MASK_WIDTH   = 16,
  parameter int DEPTH_LOG2   = 8,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 16,
  parameter int MAINT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_WIDTH-1:0] app_wdf_data,
  input  logic [MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  input  logic                  app_sr_req,
  output logic                  app_sr_active,
  input  logic                  app_ref_req,
  output logic                  app_ref_ack,
  input  logic                  app_zq_req,
  output logic                  app_zq_ack,
  output logic                  init_calib_complete
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam int MW    = $clog2(MAINT_CYCLES + 1);
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);
  localparam logic [MW-1:0] MAINT_LAST = MW'(MAINT_CYCLES - 1);

  // The byte offset and the address bits above the RAM depth are don't-care;
  // app_wdf_end carries no information since every beat is a full word.
  logic unused_bits;
  assign unused_bits = ^{app_wdf_end, app_addr};

  // ---------------------------------------------------------------- FSM
  mig7_resp_state_t state_reg, state_next;
  logic [CW-1:0]    calib_cnt_reg, calib_cnt_next;
  logic             sr_cnt_reg, sr_cnt_next;
  logic             wr_pending_reg;
  logic             fifo_full;
  logic             fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_CALIB;
      calib_cnt_reg <= '0;
      sr_cnt_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      calib_cnt_reg <= calib_cnt_next;
      sr_cnt_reg    <= sr_cnt_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    calib_cnt_next      = calib_cnt_reg;
    sr_cnt_next         = sr_cnt_reg;
    app_rdy             = 1'b0;
    app_wdf_rdy         = 1'b0;
    app_sr_active       = 1'b0;
    init_calib_complete = 1'b1;
    case (state_reg)
      ST_CALIB: begin
        init_calib_complete = 1'b0;
        if (calib_cnt_reg == CALIB_LAST) begin
          state_next = ST_READY;
        end else begin
          calib_cnt_next = calib_cnt_reg + 1'b1;
        end
      end
      ST_READY: begin
        app_rdy     = !app_sr_req && !wr_pending_reg;
        app_wdf_rdy = !fifo_full;
        // A pending write must land before the memory goes to sleep.
        if (app_sr_req && !wr_pending_reg) begin
          state_next  = ST_SR_ENTER;
          sr_cnt_next = 1'b0;
        end
      end
      ST_SR_ENTER: begin
        app_wdf_rdy = !fifo_full;
        if (sr_cnt_reg) begin
          state_next = ST_SR;
        end else begin
          sr_cnt_next = 1'b1;
        end
      end
      ST_SR: begin
        app_wdf_rdy   = !fifo_full;
        app_sr_active = 1'b1;
        if (!app_sr_req) state_next = ST_READY;
      end
      default: begin
        state_next = ST_CALIB;
      end
    endcase
  end

  // ------------------------------------------------------- command path
  logic [DEPTH_LOG2-1:0] cmd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx_reg;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  commit;
  logic [MASK_WIDTH+DATA_WIDTH-1:0] fifo_head;
  logic [MASK_WIDTH-1:0] head_mask;
  logic [DATA_WIDTH-1:0] head_data;

  assign cmd_idx   = app_addr[3 +: DEPTH_LOG2];
  assign wr_accept = app_en && app_rdy && (app_cmd == CMD_WRITE);
  assign rd_accept = app_en && app_rdy && (app_cmd == CMD_READ);
  assign commit    = wr_pending_reg && !fifo_empty;
  assign {head_mask, head_data} = fifo_head;

  mig7_resp_wdf_fifo #(
    .WIDTH(MASK_WIDTH + DATA_WIDTH)
  ) u_wdf_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (app_wdf_wren && app_wdf_rdy),
    .push_data({app_wdf_mask, app_wdf_data}),
    .pop      (commit),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // app_rdy is low while pending, so accept and commit never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pending_reg <= 1'b0;
      wr_idx_reg     <= '0;
    end else if (commit) begin
      wr_pending_reg <= 1'b0;
    end else if (wr_accept) begin
      wr_pending_reg <= 1'b1;
      wr_idx_reg     <= cmd_idx;
    end
  end

  // ---------------------------------------------------------------- RAM
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!head_mask[b]) ram[wr_idx_reg][b*8 +: 8] <= head_data[b*8 +: 8];
      end
    end
  end

  // Stage 0 is the registered RAM read; each further stage adds one cycle,
  // so the last stage is visible RD_LATENCY cycles after acceptance.
  logic [RD_LATENCY-1:0] pipe_valid_reg;
  logic [DATA_WIDTH-1:0] pipe_data_reg [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_reg <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data_reg[i] <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_data_reg[i]  <= pipe_data_reg[i-1];
      end
      pipe_valid_reg[0] <= rd_accept;
      if (rd_accept) pipe_data_reg[0] <= ram[cmd_idx];
    end
  end

  assign app_rd_data       = pipe_data_reg[RD_LATENCY-1];
  assign app_rd_data_valid = pipe_valid_reg[RD_LATENCY-1];
  assign app_rd_data_end   = pipe_valid_reg[RD_LATENCY-1];

  // ------------------------------------------------- refresh / ZQ acks
  // Channel 0 is refresh, channel 1 is ZQ. A counter value of k means the
  // request arrived k cycles ago; the ack register is loaded one edge early.
  logic [1:0] maint_req;
  logic [1:0] maint_ack;
  logic       calib_done;

  assign maint_req  = {app_zq_req, app_ref_req};
  assign calib_done = (state_reg != ST_CALIB);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_maint
      logic          armed_reg;
      logic [MW-1:0] cnt_reg;
      logic          ack_reg;
      logic          start;

      assign start = maint_req[gi] && !armed_reg && calib_done;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          armed_reg <= 1'b0;
          cnt_reg   <= '0;
          ack_reg   <= 1'b0;
        end else begin
          ack_reg <= 1'b0;
          if (start) begin
            if (MAINT_CYCLES == 1) begin
              ack_reg <= 1'b1;
            end else begin
              armed_reg <= 1'b1;
              cnt_reg   <= MW'(1);
            end
          end else if (armed_reg) begin
            if (cnt_reg == MAINT_LAST) begin
              ack_reg   <= 1'b1;
              armed_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
      end

      assign maint_ack[gi] = ack_reg;
    end
  endgenerate

  assign app_ref_ack = maint_ack[0];
  assign app_zq_ack  = maint_ack[1];

endmodule

// File: doc/mig7_app_responder.md
Name: mig7_app_responder

Overview:
- Synthesizable responder for the MIG7 user (app_*) interface, i.e. the memory-controller side that mig7_stub and future app-interface initiators talk to.
- Replaces mig7series in board bring-up builds and in block-level benches; no DDR3 pins.
- Stores data in an internal RAM, honours app_rdy/app_wdf_rdy handshakes and returns read data after a fixed latency.
- Models calibration, refresh/ZQ acks and self-refresh.

Parameters:
- ADDR_WIDTH, 28, app_addr width.
- DATA_WIDTH, 128, app data width.
- MASK_WIDTH, 16, DATA_WIDTH/8 byte mask width.
- DEPTH_LOG2, 8, log2 of the number of internal words.
- RD_LATENCY, 4, cycles from read acceptance to app_rd_data_valid (>=1).
- CALIB_CYCLES, 16, cycles after reset release before init_calib_complete (>=1).
- MAINT_CYCLES, 8, cycles from ref/zq request to ack (>=1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- app_addr  in  ADDR_WIDTH  command address.
- app_cmd  in  3  command code.
- app_en  in  1  command valid.
- app_rdy  out  1  command accepted when app_en&&app_rdy.
- app_wdf_data  in  DATA_WIDTH  write data.
- app_wdf_mask  in  MASK_WIDTH  byte mask (1 = byte not written).
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; ignored, every beat is a full word.
- app_wdf_rdy  out  1  write data accepted when wren&&wdf_rdy.
- app_rd_data  out  DATA_WIDTH  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- app_sr_req  in  1  self-refresh request (level).
- app_sr_active  out  1  self-refresh active.
- app_ref_req  in  1  refresh request (pulse).
- app_ref_ack  out  1  refresh ack (1-cycle pulse).
- app_zq_req  in  1  ZQ calibration request (pulse).
- app_zq_ack  out  1  ZQ ack (1-cycle pulse).
- init_calib_complete  out  1  calibration done.

Behaviour:
- Reset values: every output is 0; app_rd_data is 0; FIFO, pending register, read pipeline and counters are cleared. RAM contents are not cleared and are undefined after reset.
- Reset asserted mid-operation discards in-flight reads and pending writes. No valid or ack is emitted after deassertion until new requests arrive.
- FSM states: CALIB, READY, SR_ENTER, SR.
  - CALIB: counter runs CALIB_CYCLES, then goes to READY. init_calib_complete=1 from the first READY cycle onward; it stays 1 in SR_ENTER and SR.
  - READY: when app_sr_req=1 and no write is pending, go to SR_ENTER.
  - SR_ENTER: 2 cycles, then SR. app_sr_active=1 in SR.
  - SR: when app_sr_req falls, go to READY with app_sr_active=0 in the next cycle.
- Address: word index = app_addr[3 +: DEPTH_LOG2]. app_addr[2:0] and the upper bits are ignored, so the index wraps modulo 2^DEPTH_LOG2.
- Commands: 3'b000 WRITE, 3'b001 READ. Any other code is accepted with no effect.
- app_rdy = state==READY && !app_sr_req && !wr_pending.
- WRITE acceptance sets wr_pending and latches the index.
- Write data goes into a 4-entry FIFO; app_wdf_rdy = !fifo_full in every state except CALIB.
  - Data may arrive before, with or after its command.
  - Commit: in any cycle with wr_pending && !fifo_empty, RAM is written with FIFO head using byte enables ~mask, the entry is popped and wr_pending is cleared at that edge.
  - Commit occurs the same cycle command and data meet if the FIFO already holds data; otherwise on the cycle after data arrives.
- READ: the RAM is read in the accept cycle. app_rd_data_valid pulses exactly RD_LATENCY cycles later, in order, one per accepted read, back-to-back allowed.
- Read-after-write: app_rdy is low while a write is pending, so a read accepted after commit returns the committed data.
- Ref/ZQ (independent channels):
  - A request pulse while idle arms a counter; the ack pulses for 1 cycle exactly MAINT_CYCLES cycles after the request.
  - Requests while armed are ignored.
  - Requests during CALIB are ignored.

Decomposition:
- Package mig7_pkg: command constants CMD_WRITE=3'b000, CMD_READ=3'b001; state enum mig7_resp_state_t.
- Sub-module mig7_resp_wdf_fifo: 4-deep synchronous FIFO carrying {mask, data}, same clk/rst, with full/empty flags.

Test Plan:
- Reset release -> init_calib_complete rises 16 cycles later. app_rdy stays 0 until then, and app_wdf_rdy stays 0 during CALIB.
- Write data 128'h0123..CDEF with mask 0 to addr 0x10, then read 0x10 -> app_rd_data_valid and app_rd_data_end high exactly 4 cycles after read accept, with the same data.
- Write 128'hFF..FF, then a write with mask 16'h00FF and data 0 to the same address, then read -> 128'h0000..0000_FFFF..FFFF (upper 8 bytes 0, lower 8 bytes FF).
- Write command first, data 3 cycles later -> app_rdy low for those 3 cycles plus the commit cycle. Separately, 5 data beats with no command -> app_wdf_rdy drops after the 4th beat.
- 8 back-to-back reads of addrs 0x00..0x38 -> 8 consecutive valid cycles, in order. Addr 0x800 aliases addr 0 when DEPTH_LOG2=8.
- app_ref_req pulse -> app_ref_ack 8 cycles later; a second ref_req 3 cycles after the first -> no extra ack. app_sr_req=1 -> app_sr_active after 2 cycles with app_rdy=0. Async rst with a read in flight -> no valid after deassertion.
